// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode/funct encodings and shared enums for the execute stage
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   typedef enum logic {IDLE, BUSY} md_state_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_HI, ALU_LO
   } alu_op_t;

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiplier / restoring divider owning HI and LO
// op is funct[1:0] of mult/multu/div/divu: bit1 selects divide, bit0 selects unsigned.
module mul_div_unit
   import cpu_pkg::*;
#(
   parameter int MD_CYCLES = 32
) (
   input  logic        clock,
   input  logic        resetN,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        writeHi,
   input  logic        writeLo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam logic [4:0] LAST = 5'(MD_CYCLES - 1);

   md_state_t   state_q, state_d;
   logic [4:0]  count_q;
   logic [31:0] acc_q, acc_d, low_q, low_d, opnd_q, hi_q, lo_q;
   logic        is_div_q, neg_res_q, neg_rem_q, div0_q;
   logic        done, a_neg, b_neg, div_ge;
   logic [31:0] a_mag, b_mag, div_diff, quo_fix, rem_fix;
   logic [32:0] mul_sum, div_shift;
   logic [63:0] prod, prod_fix;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = BUSY;
         BUSY: if (count_q == LAST) state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == BUSY);
      done = (state_q == BUSY) && (count_q == LAST);
   end

   always_comb begin
      a_neg = ~op[0] & a[31];
      b_neg = ~op[0] & b[31];
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
      // acc holds partial product high half / running remainder, low holds multiplier / quotient
      mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : 33'd0);
      div_shift = {acc_q, low_q[31]};
      div_ge    = div_shift >= {1'b0, opnd_q};
      div_diff  = div_shift[31:0] - opnd_q;
      if (is_div_q) begin
         acc_d = div_ge ? div_diff : div_shift[31:0];
         low_d = {low_q[30:0], div_ge};
      end else begin
         acc_d = mul_sum[32:1];
         low_d = {mul_sum[0], low_q[31:1]};
      end
      prod     = {acc_d, low_d};
      prod_fix = neg_res_q ? -prod : prod;
      quo_fix  = div0_q ? 32'hFFFF_FFFF : (neg_res_q ? -low_d : low_d);
      rem_fix  = neg_rem_q ? -acc_d : acc_d;
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         count_q   <= '0;
         acc_q     <= '0;
         low_q     <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         if (state_q == IDLE && start) begin
            count_q   <= '0;
            acc_q     <= '0;
            low_q     <= a_mag;
            opnd_q    <= b_mag;
            is_div_q  <= op[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            div0_q    <= (b == 32'd0);
         end else if (busy) begin
            count_q <= count_q + 5'd1;
            acc_q   <= acc_d;
            low_q   <= low_d;
         end
         if (done) begin
            hi_q <= is_div_q ? rem_fix : prod_fix[63:32];
            lo_q <= is_div_q ? quo_fix : prod_fix[31:0];
         end else if (!busy) begin
            if (writeHi) hi_q <= wdata;
            if (writeLo) lo_q <= wdata;
         end
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: decode, ALU, branch resolution and mult/div stall generation
module ex_stage
   import cpu_pkg::*;
#(
   parameter int MD_CYCLES = 32
) (
   input  logic        clock,
   input  logic        resetN,
   input  logic        inValid,
   input  logic [31:0] instruction,
   input  logic [31:0] pc_4,
   input  logic [31:0] rsValue,
   input  logic [31:0] rtValue,
   output logic [31:0] aluResult,
   output logic [31:0] storeData,
   output logic [4:0]  writeReg,
   output logic        regWrite,
   output logic        memRead,
   output logic        memWrite,
   output logic        shouldBranch,
   output logic [31:0] branchPc,
   output logic        outValid,
   output logic        stall
);
   logic [5:0]  opcode, funct;
   logic [4:0]  rt_f, rd_f, shamt;
   logic [15:0] imm16;
   logic [31:0] imm_ext, op_b, hi, lo;
   alu_op_t     alu_op;
   logic        use_imm, imm_zext, dec_rw, dec_mr, dec_mw, dest_rd;
   logic        is_beq, is_bne, is_md, is_mth, is_mtl, hilo_class;
   logic        md_busy, fire;
   logic        unused_rs_field;

   assign opcode = instruction[31:26];
   assign rt_f   = instruction[20:16];
   assign rd_f   = instruction[15:11];
   assign shamt  = instruction[10:6];
   assign funct  = instruction[5:0];
   assign imm16  = instruction[15:0];
   // rs arrives already forwarded, so its field number is not needed here
   assign unused_rs_field = ^instruction[25:21];

   always_comb begin
      alu_op = ALU_ADD; use_imm = 1'b0; imm_zext = 1'b0; dest_rd = 1'b0;
      dec_rw = 1'b0; dec_mr = 1'b0; dec_mw = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
      is_md = 1'b0; is_mth = 1'b0; is_mtl = 1'b0; hilo_class = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            dest_rd = 1'b1;
            case (funct)
               FN_ADD, FN_ADDU: begin alu_op = ALU_ADD;  dec_rw = 1'b1; end
               FN_SUB, FN_SUBU: begin alu_op = ALU_SUB;  dec_rw = 1'b1; end
               FN_AND:          begin alu_op = ALU_AND;  dec_rw = 1'b1; end
               FN_OR:           begin alu_op = ALU_OR;   dec_rw = 1'b1; end
               FN_XOR:          begin alu_op = ALU_XOR;  dec_rw = 1'b1; end
               FN_NOR:          begin alu_op = ALU_NOR;  dec_rw = 1'b1; end
               FN_SLT:          begin alu_op = ALU_SLT;  dec_rw = 1'b1; end
               FN_SLTU:         begin alu_op = ALU_SLTU; dec_rw = 1'b1; end
               FN_SLL:          begin alu_op = ALU_SLL;  dec_rw = 1'b1; end
               FN_SRL:          begin alu_op = ALU_SRL;  dec_rw = 1'b1; end
               FN_SRA:          begin alu_op = ALU_SRA;  dec_rw = 1'b1; end
               FN_MFHI: begin alu_op = ALU_HI; dec_rw = 1'b1; hilo_class = 1'b1; end
               FN_MFLO: begin alu_op = ALU_LO; dec_rw = 1'b1; hilo_class = 1'b1; end
               FN_MTHI: begin is_mth = 1'b1; hilo_class = 1'b1; end
               FN_MTLO: begin is_mtl = 1'b1; hilo_class = 1'b1; end
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin is_md = 1'b1; hilo_class = 1'b1; end
               default: ;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin use_imm = 1'b1; dec_rw = 1'b1; end
         OP_SLTI:  begin alu_op = ALU_SLT;  use_imm = 1'b1; dec_rw = 1'b1; end
         OP_SLTIU: begin alu_op = ALU_SLTU; use_imm = 1'b1; dec_rw = 1'b1; end
         OP_ANDI:  begin alu_op = ALU_AND; use_imm = 1'b1; imm_zext = 1'b1; dec_rw = 1'b1; end
         OP_ORI:   begin alu_op = ALU_OR;  use_imm = 1'b1; imm_zext = 1'b1; dec_rw = 1'b1; end
         OP_XORI:  begin alu_op = ALU_XOR; use_imm = 1'b1; imm_zext = 1'b1; dec_rw = 1'b1; end
         OP_LUI:   begin alu_op = ALU_LUI; dec_rw = 1'b1; end
         OP_LW:    begin use_imm = 1'b1; dec_rw = 1'b1; dec_mr = 1'b1; end
         OP_SW:    begin use_imm = 1'b1; dec_mw = 1'b1; end
         OP_BEQ:   is_beq = 1'b1;
         OP_BNE:   is_bne = 1'b1;
         default: ;
      endcase
   end

   assign imm_ext = imm_zext ? {16'h0, imm16} : {{16{imm16[15]}}, imm16};
   assign op_b    = use_imm ? imm_ext : rtValue;

   always_comb begin
      case (alu_op)
         ALU_ADD:  aluResult = rsValue + op_b;
         ALU_SUB:  aluResult = rsValue - op_b;
         ALU_AND:  aluResult = rsValue & op_b;
         ALU_OR:   aluResult = rsValue | op_b;
         ALU_XOR:  aluResult = rsValue ^ op_b;
         ALU_NOR:  aluResult = ~(rsValue | op_b);
         ALU_SLT:  aluResult = {31'd0, $signed(rsValue) < $signed(op_b)};
         ALU_SLTU: aluResult = {31'd0, rsValue < op_b};
         ALU_SLL:  aluResult = rtValue << shamt;
         ALU_SRL:  aluResult = rtValue >> shamt;
         ALU_SRA:  aluResult = $signed(rtValue) >>> shamt;
         ALU_LUI:  aluResult = {imm16, 16'h0};
         ALU_HI:   aluResult = hi;
         ALU_LO:   aluResult = lo;
         default:  aluResult = rsValue + op_b;
      endcase
   end

   assign stall        = inValid & md_busy & hilo_class;
   assign fire         = inValid & ~stall;
   assign outValid     = fire;
   assign regWrite     = fire & dec_rw;
   assign memRead      = fire & dec_mr;
   assign memWrite     = fire & dec_mw;
   assign writeReg     = regWrite ? (dest_rd ? rd_f : rt_f) : 5'd0;
   assign storeData    = rtValue;
   assign branchPc     = pc_4 + {{14{imm16[15]}}, imm16, 2'b00};
   assign shouldBranch = fire & ((is_beq & (rsValue == rtValue)) | (is_bne & (rsValue != rtValue)));

   mul_div_unit #(.MD_CYCLES(MD_CYCLES)) u_md (
      .clock   (clock),
      .resetN  (resetN),
      .start   (fire & is_md),
      .op      (funct[1:0]),
      .a       (rsValue),
      .b       (rtValue),
      .writeHi (fire & is_mth),
      .writeLo (fire & is_mtl),
      .wdata   (rsValue),
      .busy    (md_busy),
      .hi      (hi),
      .lo      (lo)
   );

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed table and sequence checks for ex_stage
module tb_ex_stage;
   logic        clock, resetN, inValid;
   logic [31:0] instruction, pc_4, rsValue, rtValue;
   logic [31:0] aluResult, storeData, branchPc;
   logic [4:0]  writeReg;
   logic        regWrite, memRead, memWrite, shouldBranch, outValid, stall;

   int passed = 0;
   int total  = 0;

   ex_stage #(.MD_CYCLES(32)) dut (
      .clock(clock), .resetN(resetN), .inValid(inValid), .instruction(instruction),
      .pc_4(pc_4), .rsValue(rsValue), .rtValue(rtValue), .aluResult(aluResult),
      .storeData(storeData), .writeReg(writeReg), .regWrite(regWrite), .memRead(memRead),
      .memWrite(memWrite), .shouldBranch(shouldBranch), .branchPc(branchPc),
      .outValid(outValid), .stall(stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] ins, pc4, rs, rt, alu, bpc;
      logic [4:0]  wreg;
      logic [3:0]  ctl;     // {regWrite, memRead, memWrite, shouldBranch}
      logic        chk_alu, chk_bpc;
   } vec_t;
   vec_t vecs[$];

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic void addv(input logic [31:0] ins, input logic [31:0] pc4,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] alu, input logic chk_alu,
                                input logic [4:0] wreg, input logic [3:0] ctl,
                                input logic [31:0] bpc, input logic chk_bpc);
      vec_t v;
      v.ins = ins; v.pc4 = pc4; v.rs = rs; v.rt = rt; v.alu = alu; v.chk_alu = chk_alu;
      v.wreg = wreg; v.ctl = ctl; v.bpc = bpc; v.chk_bpc = chk_bpc;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b);
      inValid = v; instruction = ins; pc_4 = pc; rsValue = a; rtValue = b;
   endtask

   logic [31:0] mfhi_i, mflo_i, addu_i;

   task automatic wait_unstall(input string nm, input int exp_cycles);
      int cnt = 0;
      while (stall && cnt < 100) begin
         cnt++;
         @(negedge clock); #1;
      end
      chk({nm, " stall cycles"}, cnt, exp_cycles);
   endtask

   task automatic run_md(input string nm, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      @(negedge clock); drive(1'b1, ins, 32'h0, a, b); #1;
      chk({nm, " issue stall"}, stall, 1'b0);
      chk({nm, " issue outValid"}, outValid, 1'b1);
      chk({nm, " issue regWrite"}, regWrite, 1'b0);
      @(negedge clock); drive(1'b1, mfhi_i, 32'h0, 32'h0, 32'h0); #1;
      wait_unstall(nm, 32);
      chk({nm, " hi"}, aluResult, eh);
      @(negedge clock); drive(1'b1, mflo_i, 32'h0, 32'h0, 32'h0); #1;
      chk({nm, " lo stall"}, stall, 1'b0);
      chk({nm, " lo"}, aluResult, el);
      @(negedge clock); inValid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      mfhi_i = rtype(0, 0, 2, 0, 6'h10);
      mflo_i = rtype(0, 0, 2, 0, 6'h12);
      addu_i = rtype(1, 2, 3, 0, 6'h21);

      addv(itype(6'h08, 1, 8, 16'h0001), 0, 32'h7FFF_FFFF, 0, 32'h8000_0000, 1, 8, 4'b1000, 0, 0);
      addv(addu_i, 0, 5, 7, 32'h0000_000C, 1, 3, 4'b1000, 0, 0);
      addv(rtype(1, 2, 3, 0, 6'h22), 0, 5, 7, 32'hFFFF_FFFE, 1, 3, 4'b1000, 0, 0);
      addv(rtype(1, 2, 3, 0, 6'h24), 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, 3, 4'b1000, 0, 0);
      addv(rtype(1, 2, 3, 0, 6'h25), 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1, 3, 4'b1000, 0, 0);
      addv(rtype(1, 2, 3, 0, 6'h26), 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 3, 4'b1000, 0, 0);
      addv(rtype(1, 2, 3, 0, 6'h27), 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1, 3, 4'b1000, 0, 0);
      addv(rtype(1, 2, 3, 0, 6'h2A), 0, 32'hFFFF_FFFF, 1, 32'h1, 1, 3, 4'b1000, 0, 0);
      addv(rtype(1, 2, 3, 0, 6'h2B), 0, 32'hFFFF_FFFF, 1, 32'h0, 1, 3, 4'b1000, 0, 0);
      addv(rtype(0, 2, 3, 31, 6'h00), 0, 0, 1, 32'h8000_0000, 1, 3, 4'b1000, 0, 0);
      addv(rtype(0, 2, 3, 4, 6'h02), 0, 0, 32'h8000_0000, 32'h0800_0000, 1, 3, 4'b1000, 0, 0);
      addv(rtype(0, 2, 3, 4, 6'h03), 0, 0, 32'h8000_0000, 32'hF800_0000, 1, 3, 4'b1000, 0, 0);
      addv(itype(6'h0A, 1, 9, 16'hFFFF), 0, 32'hFFFF_FFFB, 0, 32'h1, 1, 9, 4'b1000, 0, 0);
      addv(itype(6'h0B, 1, 9, 16'hFFFF), 0, 5, 0, 32'h1, 1, 9, 4'b1000, 0, 0);
      addv(itype(6'h0C, 1, 9, 16'h8001), 0, 32'hFFFF_FFFF, 0, 32'h0000_8001, 1, 9, 4'b1000, 0, 0);
      addv(itype(6'h0D, 1, 9, 16'hFFFF), 0, 0, 0, 32'h0000_FFFF, 1, 9, 4'b1000, 0, 0);
      addv(itype(6'h0E, 1, 9, 16'hFFFF), 0, 32'hFFFF_0000, 0, 32'hFFFF_FFFF, 1, 9, 4'b1000, 0, 0);
      addv(itype(6'h0F, 0, 9, 16'h1234), 0, 0, 0, 32'h1234_0000, 1, 9, 4'b1000, 0, 0);
      addv(itype(6'h23, 1, 9, 16'hFFFC), 0, 32'h1000, 0, 32'h0000_0FFC, 1, 9, 4'b1100, 0, 0);
      addv(itype(6'h2B, 1, 9, 16'h0008), 0, 32'h1000, 32'hDEAD_BEEF, 32'h0000_1008, 1, 0, 4'b0010, 0, 0);
      addv(itype(6'h04, 1, 2, 16'hFFFF), 32'h100, 5, 5, 0, 0, 0, 4'b0001, 32'h0000_00FC, 1);
      addv(itype(6'h04, 1, 2, 16'hFFFF), 32'h100, 5, 6, 0, 0, 0, 4'b0000, 32'h0000_00FC, 1);
      addv(itype(6'h05, 1, 2, 16'h0002), 32'h200, 5, 6, 0, 0, 0, 4'b0001, 32'h0000_0208, 1);
      addv(itype(6'h05, 1, 2, 16'h0002), 32'h200, 5, 5, 0, 0, 0, 4'b0000, 32'h0000_0208, 1);
      addv(itype(6'h3F, 1, 9, 16'h1234), 0, 1, 2, 0, 0, 0, 4'b0000, 0, 0);
      addv(rtype(1, 2, 3, 0, 6'h3F), 0, 1, 2, 0, 0, 0, 4'b0000, 0, 0);

      resetN = 1'b0;
      drive(1'b0, addu_i, 0, 5, 7);
      #1;
      chk("reset stall", stall, 1'b0);
      chk("reset outValid", outValid, 1'b0);
      drive(1'b1, mfhi_i, 0, 0, 0); #1;
      chk("reset hi", aluResult, 32'h0);
      @(negedge clock); resetN = 1'b1; inValid = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clock);
         drive(1'b1, vecs[i].ins, vecs[i].pc4, vecs[i].rs, vecs[i].rt); #1;
         if (vecs[i].chk_alu) chk($sformatf("v%0d alu", i), aluResult, vecs[i].alu);
         if (vecs[i].chk_bpc) chk($sformatf("v%0d branchPc", i), branchPc, vecs[i].bpc);
         chk($sformatf("v%0d writeReg", i), writeReg, vecs[i].wreg);
         chk($sformatf("v%0d ctl", i), {regWrite, memRead, memWrite, shouldBranch}, vecs[i].ctl);
         chk($sformatf("v%0d storeData", i), storeData, vecs[i].rt);
         chk($sformatf("v%0d outValid", i), {outValid, stall}, 2'b10);
      end

      @(negedge clock); drive(1'b0, itype(6'h23, 1, 9, 16'h0), 0, 5, 7); #1;
      chk("bubble ctl", {regWrite, memRead, memWrite, shouldBranch, outValid}, 5'b0);
      chk("bubble writeReg", writeReg, 5'd0);

      // mthi/mtlo while idle
      @(negedge clock); drive(1'b1, rtype(1, 0, 0, 0, 6'h11), 0, 32'hABCD_1234, 0); #1;
      chk("mthi regWrite", regWrite, 1'b0);
      @(negedge clock); drive(1'b1, rtype(1, 0, 0, 0, 6'h13), 0, 32'h5555_AAAA, 0);
      @(negedge clock); drive(1'b1, mfhi_i, 0, 0, 0); #1;
      chk("mthi readback", aluResult, 32'hABCD_1234);
      @(negedge clock); drive(1'b1, mflo_i, 0, 0, 0); #1;
      chk("mtlo readback", aluResult, 32'h5555_AAAA);

      run_md("mult", rtype(1, 2, 0, 0, 6'h18), 32'hFFFF_FFFE, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_md("multu", rtype(1, 2, 0, 0, 6'h19), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_md("div", rtype(1, 2, 0, 0, 6'h1A), 7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      run_md("div negdvd", rtype(1, 2, 0, 0, 6'h1A), 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("divu0", rtype(1, 2, 0, 0, 6'h1B), 5, 0, 32'h0000_0005, 32'hFFFF_FFFF);
      run_md("divu", rtype(1, 2, 0, 0, 6'h1B), 100, 7, 32'h0000_0002, 32'h0000_000E);

      // independent instructions flow past a busy unit
      begin
         int stalls = 0;
         @(negedge clock); drive(1'b1, rtype(1, 2, 0, 0, 6'h18), 0, 32'h0001_0000, 32'h0001_0000);
         for (int k = 0; k < 10; k++) begin
            @(negedge clock); drive(1'b1, addu_i, 0, k, 100); #1;
            if (stall) stalls++;
            chk($sformatf("flow addu %0d", k), aluResult, 32'(k + 100));
         end
         chk("flow stall count", stalls, 0);
      end
      @(negedge clock); inValid = 1'b0;
      repeat (30) @(posedge clock);
      @(negedge clock); drive(1'b1, mfhi_i, 0, 0, 0); #1;
      chk("late mfhi stall", stall, 1'b0);
      chk("late mfhi", aluResult, 32'h0000_0001);

      // mthi while busy stalls; reset at counter 15 aborts and clears HI/LO
      @(negedge clock); drive(1'b1, rtype(1, 2, 0, 0, 6'h18), 0, 32'hFFFF_FFFE, 3);
      @(negedge clock); drive(1'b1, rtype(1, 0, 0, 0, 6'h11), 0, 32'h1111_1111, 0); #1;
      chk("busy mthi stall", stall, 1'b1);
      chk("busy mthi outValid", outValid, 1'b0);
      repeat (15) @(posedge clock);
      @(negedge clock); drive(1'b1, mfhi_i, 0, 0, 0);
      resetN = 1'b0; #1;
      chk("abort stall", stall, 1'b0);
      chk("abort hi", aluResult, 32'h0);
      drive(1'b1, mflo_i, 0, 0, 0); #1;
      chk("abort lo", aluResult, 32'h0);
      @(negedge clock); resetN = 1'b1; drive(1'b1, mfhi_i, 0, 0, 0);
      @(negedge clock); #1;
      chk("post reset mfhi stall", stall, 1'b0);
      chk("post reset mfhi", aluResult, 32'h0);

      @(negedge clock); inValid = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
